// File: rtl/mult_scheduler.sv
// Two-requester round-robin front end feeding a serial shift-add multiplier.
// One operand pair is in flight at a time; the result is held until the consumer takes it.
module mult_scheduler #(
   parameter int unsigned WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req0_valid,
   input  logic [WIDTH-1:0]     req0_a,
   input  logic [WIDTH-1:0]     req0_b,
   output logic                 req0_ready,
   input  logic                 req1_valid,
   input  logic [WIDTH-1:0]     req1_a,
   input  logic [WIDTH-1:0]     req1_b,
   output logic                 req1_ready,
   output logic                 res_valid,
   output logic [2*WIDTH-1:0]   res_prod,
   output logic                 res_id,
   input  logic                 res_ready,
   output logic                 busy
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             r_state;
   logic               r_rr;
   logic [CW-1:0]      r_cnt;
   logic [WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]   r_mplr;
   logic [WIDTH-1:0]   r_acc;
   logic               r_id_cap;
   logic [2*WIDTH-1:0] r_res_prod;
   logic               r_res_id;

   logic               w_idle;
   logic               w_grant0;
   logic               w_grant1;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH-1:0]   w_acc_nx;
   logic [WIDTH-1:0]   w_mplr_nx;

   // Grants are gated by rst_n so both readys read 0 for the whole reset window.
   assign w_idle   = rst_n && (r_state == IDLE);
   assign w_grant0 = w_idle && req0_valid && (!req1_valid || !r_rr);
   assign w_grant1 = w_idle && req1_valid && (!req0_valid ||  r_rr);

   // Carry kept in the extra bit, then {carry, acc, mplr} shifts right by one.
   assign w_sum     = r_mplr[0] ? ({1'b0, r_acc} + {1'b0, r_mcand}) : {1'b0, r_acc};
   assign w_acc_nx  = w_sum[WIDTH:1];
   assign w_mplr_nx = {w_sum[0], r_mplr[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_rr       <= 1'b0;
         r_cnt      <= '0;
         r_mcand    <= '0;
         r_mplr     <= '0;
         r_acc      <= '0;
         r_id_cap   <= 1'b0;
         r_res_prod <= '0;
         r_res_id   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_grant0 || w_grant1) begin
                  r_mcand  <= w_grant1 ? req1_b : req0_b;
                  r_mplr   <= w_grant1 ? req1_a : req0_a;
                  r_acc    <= '0;
                  r_cnt    <= '0;
                  r_id_cap <= w_grant1;
                  r_rr     <= w_grant0;
                  r_state  <= CALC;
               end
            end
            CALC: begin
               r_acc  <= w_acc_nx;
               r_mplr <= w_mplr_nx;
               r_cnt  <= r_cnt + CW'(1);
               if (r_cnt == CW'(WIDTH - 1)) begin
                  r_res_prod <= {w_acc_nx, w_mplr_nx};
                  r_res_id   <= r_id_cap;
                  r_state    <= DONE;
               end
            end
            DONE: begin
               if (res_ready) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign req0_ready = w_grant0;
   assign req1_ready = w_grant1;
   assign res_valid  = (r_state == DONE);
   assign busy       = (r_state != IDLE);
   assign res_prod   = r_res_prod;
   assign res_id     = r_res_id;

endmodule

// File: doc/mult_scheduler.md
MULT_SCHEDULER -- requirements
Module: mult_scheduler

Interface
REQ-001 Parameter WIDTH, default 4: operand width in bits; all arithmetic is unsigned.
REQ-002 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 Port req0_valid, input, 1: requester 0 has an operand pair pending.
REQ-005 Port req0_a, input, WIDTH: requester 0 multiplier.
REQ-006 Port req0_b, input, WIDTH: requester 0 multiplicand.
REQ-007 Port req0_ready, output, 1: requester 0 operands accepted this cycle.
REQ-008 Ports req1_valid, req1_a, req1_b and req1_ready SHALL mirror REQ-004..REQ-007 for requester 1.
REQ-009 Port res_valid, output, 1: result available.
REQ-010 Port res_prod, output, 2*WIDTH: product.
REQ-011 Port res_id, output, 1: index of the requester that owns res_prod.
REQ-012 Port res_ready, input, 1: consumer accepts the result.
REQ-013 Port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-014 The block SHALL be a three-state FSM with states IDLE, CALC and DONE.
REQ-015 In IDLE, the block SHALL assert readyN combinationally for exactly one valid requester and for no other.
- If only one requester is valid, that requester is selected.
- If both are valid, the requester favoured by the round-robin pointer is selected.
REQ-016 A request is accepted on the clock edge where validN and readyN are both high.
- On that edge, a, b and N are captured.
- The iteration counter is set to 0.
- The state becomes CALC.
REQ-017 After an accept of N, the round-robin pointer SHALL favour the other requester; the pointer SHALL be unchanged otherwise.
REQ-018 Both ready outputs SHALL be 0 in CALC and DONE; requester inputs SHALL be ignored outside the accept edge.
REQ-019 A requester SHALL be allowed to drop valid before it is accepted, with no side effect.
REQ-020 CALC SHALL perform one shift-add iteration per cycle, for exactly WIDTH cycles.
- Each iteration examines the LSB of the multiplier register.
- The add SHALL use a WIDTH+1-bit accumulator so that the carry is retained.
- After the add, {carry, acc, multiplier} shifts right by one.
REQ-021 After the WIDTH-th iteration edge, the state SHALL become DONE.
- res_prod is loaded with the exact unsigned product a*b.
- res_id is loaded with the captured N.
- Latency is WIDTH clock edges from the accept edge to res_valid being high.
REQ-022 In DONE, res_valid SHALL be 1.
- res_prod and res_id SHALL stay stable until res_ready is sampled high.
- On that edge, the state SHALL return to IDLE.
REQ-023 Outside DONE, res_valid SHALL be 0, and res_prod and res_id SHALL hold their last loaded values.
REQ-024 A new accept SHALL be possible on the first IDLE cycle after the result handshake; no accept SHALL occur in the same cycle as that handshake.
REQ-025 Operand values of 0 and of all ones SHALL produce exact products with no overflow; 2*WIDTH bits always suffice.

Reset
REQ-026 While rst_n is 0, the block SHALL hold these values regardless of clk:
- state IDLE;
- res_valid 0, res_prod 0, res_id 0;
- req0_ready 0, req1_ready 0, busy 0;
- round-robin pointer favouring requester 0;
- counter 0.
REQ-027 Reset asserted in CALC or DONE SHALL discard the in-flight operation, with no result emitted.
REQ-028 After rst_n deasserts, the first rising edge SHALL behave as IDLE.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- req0 only, a=4'hF, b=4'hF -> req0_ready same cycle; res_valid 4 edges after accept; res_prod=8'hE1, res_id=0.
- From reset, both valid (req0 a=3, b=5; req1 a=7, b=9) -> first result id 0, prod 8'h0F; req1 accepted on the first IDLE cycle after that handshake; second result id 1, prod 8'h3F.
- res_ready held low 3 cycles in DONE -> res_valid, res_prod, res_id stable; both readys 0; busy 1.
- a=0, b=4'hB -> prod 8'h00; then a=1, b=4'hB -> prod 8'h0B; a=4'hB, b=1 -> prod 8'h0B.
- rst_n pulsed low at the 2nd CALC cycle -> all outputs 0 immediately; no result emitted; next req1 request a=2, b=6 -> prod 8'h0C, id 1.
- Both requesters valid continuously, res_ready tied 1, 4 transactions -> res_id sequence 0,1,0,1.
